// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit teaching RISC: opcodes and instruction field positions.
// No logic, so no latency.
// No handshake or backpressure.
package risc_pkg;

  // Instruction field slice positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 5;

  // 5-bit opcodes
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_NOT  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_MOV  = 5'b01000;
  localparam logic [4:0] OP_MVI  = 5'b01001;
  localparam logic [4:0] OP_ADDI = 5'b01010;
  localparam logic [4:0] OP_INC  = 5'b01011;
  localparam logic [4:0] OP_DEC  = 5'b01100;
  localparam logic [4:0] OP_LDA  = 5'b01101;
  localparam logic [4:0] OP_STA  = 5'b01110;
  localparam logic [4:0] OP_JMP  = 5'b01111;
  localparam logic [4:0] OP_JZ   = 5'b10000;
  localparam logic [4:0] OP_JC   = 5'b10001;

endpackage

// File: rtl/execute_alu8.sv
// Combinational 8-bit ALU: data result, carry/borrow out and flag-update enables.
// Zero latency (pure combinational).
// No handshake or backpressure.
module alu8
  import risc_pkg::*;
(
  input  logic [4:0] opcode_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [7:0] imm_i,
  input  logic       cin_unused_i,
  output logic [7:0] result_o,
  output logic       cout_o,
  output logic       zf_en_o,
  output logic       cf_en_o
);

  logic [8:0] sum9;

  // Opcode decode; address-sourced opcodes and reserved ones yield zero with no flag update
  always_comb begin
    sum9     = '0;
    result_o = '0;
    cout_o   = 1'b0;
    zf_en_o  = 1'b0;
    cf_en_o  = 1'b0;
    unique case (opcode_i)
      OP_ADD: begin
        sum9     = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum9[7:0];
        cout_o   = sum9[8];
        zf_en_o  = 1'b1;
        cf_en_o  = 1'b1;
      end
      // Bit 8 of a 9-bit difference is the borrow
      OP_SUB: begin
        sum9     = {1'b0, a_i} - {1'b0, b_i};
        result_o = sum9[7:0];
        cout_o   = sum9[8];
        zf_en_o  = 1'b1;
        cf_en_o  = 1'b1;
      end
      OP_AND: begin result_o = a_i & b_i; zf_en_o = 1'b1; cf_en_o = 1'b1; end
      OP_OR:  begin result_o = a_i | b_i; zf_en_o = 1'b1; cf_en_o = 1'b1; end
      OP_XOR: begin result_o = a_i ^ b_i; zf_en_o = 1'b1; cf_en_o = 1'b1; end
      OP_NOT: begin result_o = ~a_i;      zf_en_o = 1'b1; cf_en_o = 1'b1; end
      OP_SHL: begin
        result_o = {a_i[6:0], 1'b0};
        cout_o   = a_i[7];
        zf_en_o  = 1'b1;
        cf_en_o  = 1'b1;
      end
      OP_SHR: begin
        result_o = {1'b0, a_i[7:1]};
        cout_o   = a_i[0];
        zf_en_o  = 1'b1;
        cf_en_o  = 1'b1;
      end
      OP_MOV: result_o = b_i;
      OP_MVI: result_o = imm_i;
      OP_ADDI: begin
        sum9     = {1'b0, a_i} + {1'b0, imm_i};
        result_o = sum9[7:0];
        cout_o   = sum9[8];
        zf_en_o  = 1'b1;
        cf_en_o  = 1'b1;
      end
      OP_INC: begin
        sum9     = {1'b0, a_i} + 9'd1;
        result_o = sum9[7:0];
        cout_o   = sum9[8];
        zf_en_o  = 1'b1;
        cf_en_o  = 1'b1;
      end
      OP_DEC: begin
        sum9     = {1'b0, a_i} - 9'd1;
        result_o = sum9[7:0];
        cout_o   = sum9[8];
        zf_en_o  = 1'b1;
        cf_en_o  = 1'b1;
      end
      OP_STA: result_o = a_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/execute.sv
// Execute stage: registers the ALU/jump result into ALUOUT and maintains ZF/CF.
// One T1 edge of latency; outputs hold between edges.
// No handshake: a new instruction is accepted on every edge, never stalls.
module execute
  import risc_pkg::*;
(
  input  logic        T1,
  input  logic [7:0]  valA,
  input  logic [7:0]  valB,
  input  logic [7:0]  X,
  input  logic [15:0] Addr,
  input  logic [15:0] IR,
  output logic [7:0]  ALUOUT,
  input  logic        rst,
  output logic        ZF,
  output logic        CF
);

  logic [4:0]  opcode;
  logic [7:0]  alu_res;
  logic        alu_cout;
  logic        alu_zf_en;
  logic        alu_cf_en;
  logic [7:0]  aluout_d, aluout_q;
  logic        zf_d, zf_q;
  logic        cf_d, cf_q;
  // Register indices, IR low bits and the address high byte do not influence this stage
  logic [18:0] unused_bits;

  assign opcode      = IR[OPC_HI:OPC_LO];
  assign unused_bits = {IR[10:0], Addr[15:8]};

  alu8 u_alu8 (
    .opcode_i     (opcode),
    .a_i          (valA),
    .b_i          (valB),
    .imm_i        (X),
    .cin_unused_i (1'b0),
    .result_o     (alu_res),
    .cout_o       (alu_cout),
    .zf_en_o      (alu_zf_en),
    .cf_en_o      (alu_cf_en)
  );

  // Result mux (ALU vs address/jump paths) and flag next-state; jumps test the held flags
  always_comb begin
    aluout_d = alu_res;
    zf_d     = zf_q;
    cf_d     = cf_q;
    case (opcode)
      OP_LDA, OP_JMP: aluout_d = Addr[7:0];
      OP_JZ:          aluout_d = zf_q ? Addr[7:0] : 8'h00;
      OP_JC:          aluout_d = cf_q ? Addr[7:0] : 8'h00;
      default: ;
    endcase
    if (alu_zf_en) zf_d = (alu_res == 8'h00);
    if (alu_cf_en) cf_d = alu_cout;
  end

  // Stage registers with synchronous reset taking priority over the instruction
  always_ff @(posedge T1) begin
    if (rst) begin
      aluout_q <= 8'h00;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
    end else begin
      aluout_q <= aluout_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
    end
  end

  assign ALUOUT = aluout_q;
  assign ZF     = zf_q;
  assign CF     = cf_q;

endmodule

// File: tb/tb_execute.sv
// Bench for execute: directed test-plan sequence plus random instructions vs a behavioural model.
// Outputs sampled 1 time unit after each rising T1 edge.
// No handshake in the DUT; every edge is checked.
module tb_execute;

  logic        T1;
  logic        rst;
  logic [7:0]  valA, valB, X;
  logic [15:0] Addr, IR;
  logic [7:0]  ALUOUT;
  logic        ZF, CF;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model state
  int m_alu = 0;
  bit m_z   = 0;
  bit m_c   = 0;

  execute dut (
    .T1     (T1),
    .valA   (valA),
    .valB   (valB),
    .X      (X),
    .Addr   (Addr),
    .IR     (IR),
    .ALUOUT (ALUOUT),
    .rst    (rst),
    .ZF     (ZF),
    .CF     (CF)
  );

  initial begin
    T1 = 1'b0;
    forever #5 T1 = ~T1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Plain-arithmetic reference for one edge
  task automatic model_edge(input bit r, input int op, input int a, input int b,
                            input int x, input int addr);
    int res;
    bit nc, uz, uc;
    res = 0; nc = 0; uz = 0; uc = 0;
    if (r) begin
      m_alu = 0; m_z = 0; m_c = 0;
      return;
    end
    case (op)
      0:  begin res = a + b;  nc = (a + b) > 255; uz = 1; uc = 1; end
      1:  begin res = a - b;  nc = a < b;         uz = 1; uc = 1; end
      2:  begin res = a & b;  uz = 1; uc = 1; end
      3:  begin res = a | b;  uz = 1; uc = 1; end
      4:  begin res = a ^ b;  uz = 1; uc = 1; end
      5:  begin res = 255 - a; uz = 1; uc = 1; end
      6:  begin res = a * 2;  nc = a >= 128;  uz = 1; uc = 1; end
      7:  begin res = a / 2;  nc = (a % 2) == 1; uz = 1; uc = 1; end
      8:  res = b;
      9:  res = x;
      10: begin res = a + x;  nc = (a + x) > 255; uz = 1; uc = 1; end
      11: begin res = a + 1;  nc = a == 255;  uz = 1; uc = 1; end
      12: begin res = a - 1;  nc = a == 0;    uz = 1; uc = 1; end
      13: res = addr % 256;
      14: res = a;
      15: res = addr % 256;
      16: res = m_z ? addr % 256 : 0;
      17: res = m_c ? addr % 256 : 0;
      default: res = 0;
    endcase
    res = (res + 256) % 256;
    m_alu = res;
    if (uz) m_z = (res == 0);
    if (uc) m_c = nc;
  endtask

  // Drive one instruction, clock it, then compare DUT against the model
  task automatic step(input bit r, input logic [4:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] x, input logic [15:0] addr,
                      input logic [10:0] low);
    @(negedge T1);
    rst  = r;
    IR   = {op, low};
    valA = a;
    valB = b;
    X    = x;
    Addr = addr;
    @(posedge T1);
    model_edge(r, int'(op), int'(a), int'(b), int'(x), int'(addr));
    #1;
    check("model_aluout", int'(ALUOUT), m_alu);
    check("model_zf", int'(ZF), int'(m_z));
    check("model_cf", int'(CF), int'(m_c));
  endtask

  // Hand-computed literal expectations
  task automatic expect_lit(input string name, input logic [7:0] e_alu,
                            input logic e_z, input logic e_c);
    check({name, "_aluout"}, int'(ALUOUT), int'(e_alu));
    check({name, "_zf"}, int'(ZF), int'(e_z));
    check({name, "_cf"}, int'(CF), int'(e_c));
  endtask

  initial begin
    logic [4:0] rop;
    rst = 1'b1; IR = '0; valA = '0; valB = '0; X = '0; Addr = '0;

    step(1, 5'b00000, 8'h00, 8'h00, 8'h00, 16'h0000, 11'h020);
    expect_lit("reset", 8'h00, 0, 0);
    step(0, 5'b00000, 8'h01, 8'h0E, 8'h0F, 16'h0001, 11'h020);
    expect_lit("add", 8'h0F, 0, 0);
    step(0, 5'b00000, 8'hFF, 8'h01, 8'h00, 16'h0000, 11'h020);
    expect_lit("add_carry", 8'h00, 1, 1);
    step(0, 5'b10000, 8'h00, 8'h00, 8'h00, 16'h1234, 11'h020);
    expect_lit("jz_taken", 8'h34, 1, 1);
    step(0, 5'b00001, 8'h03, 8'h05, 8'h00, 16'h0000, 11'h020);
    expect_lit("sub_borrow", 8'hFE, 0, 1);
    step(0, 5'b10001, 8'h00, 8'h00, 8'h00, 16'h00AB, 11'h020);
    expect_lit("jc_taken", 8'hAB, 0, 1);
    step(0, 5'b00010, 8'h0F, 8'hF0, 8'h00, 16'h0000, 11'h020);
    expect_lit("and_zero", 8'h00, 1, 0);
    step(0, 5'b10001, 8'h00, 8'h00, 8'h00, 16'h00AB, 11'h020);
    expect_lit("jc_not_taken", 8'h00, 1, 0);
    step(0, 5'b01001, 8'h00, 8'h00, 8'h5A, 16'h0000, 11'h020);
    expect_lit("mvi", 8'h5A, 1, 0);
    step(0, 5'b01010, 8'hF0, 8'h00, 8'h20, 16'h0000, 11'h020);
    expect_lit("addi", 8'h10, 0, 1);
    step(0, 5'b01101, 8'h00, 8'h00, 8'h00, 16'hBEEF, 11'h020);
    expect_lit("lda", 8'hEF, 0, 1);
    step(0, 5'b00110, 8'h81, 8'h00, 8'h00, 16'h0000, 11'h020);
    expect_lit("shl", 8'h02, 0, 1);
    step(0, 5'b00111, 8'h01, 8'h00, 8'h00, 16'h0000, 11'h020);
    expect_lit("shr", 8'h00, 1, 1);
    step(0, 5'b01000, 8'h00, 8'h0F, 8'h00, 16'h0000, 11'h020);
    expect_lit("mov", 8'h0F, 1, 1);
    step(1, 5'b00000, 8'h01, 8'h0E, 8'h00, 16'h0000, 11'h020);
    expect_lit("mid_reset", 8'h00, 0, 0);
    step(0, 5'b00000, 8'h01, 8'h0E, 8'h00, 16'h0000, 11'h020);
    expect_lit("after_reset", 8'h0F, 0, 0);
    step(0, 5'b01100, 8'h00, 8'h00, 8'h00, 16'h0000, 11'h020);
    expect_lit("dec_borrow", 8'hFF, 0, 1);
    step(0, 5'b11111, 8'h12, 8'h34, 8'h56, 16'h7890, 11'h020);
    expect_lit("reserved", 8'h00, 0, 1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rop = 5'($urandom_range(0, 31));
      else rop = 5'($urandom_range(0, 17));
      step($urandom_range(0, 19) == 0, rop, 8'($urandom), 8'($urandom),
           8'($urandom), 16'($urandom), 11'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
